fft16_ser2par: RTL and testbench
================================

# fft16_ser2par

Input-side serial-to-parallel frame assembler for the 16-point FFT datapath. It accepts complex samples two per cycle and assembles them into a full 16-point frame, then presents that frame in parallel to the FFT butterfly core. It is ping-pong double-buffered, so a new frame can be filled while the core consumes the previous one. It is the mirror of the output serializer at the other end of the core.

## Interface
- DW, 16, real/imag sample width (two's complement)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_sof  in  1  start-of-frame marker, qualified by in_valid
- in0_re, in0_im  in  DW each  sample 2k of the frame (beat k)
- in1_re, in1_im  in  DW each  sample 2k+1 of the frame (beat k)
- out_valid  out  1  complete frame available
- out_ready  in  1  core takes frame when out_valid && out_ready
- out_re, out_im  out  16*DW each  frame; sample n occupies bits [n*DW +: DW]
- frame_err  out  1  one-cycle pulse: frame discarded by resync

## Operation
- State: two buffers B0/B1 (16 complex words each), full flags f[1:0], write pointer wp, read pointer rp, 3-bit beat counter bc.
- Reset values: f=00, wp=0, rp=0, bc=0, frame_err=0, all buffer words 0. Therefore out_valid=0, out_re/out_im=0, in_ready=1.
- in_ready = !f[wp]. It is registered-state only; there is no combinational path from out_ready or in_valid.
- On beat accept, the sample pair is written into buf[wp] at indices 2*bc and 2*bc+1, then bc increments.
- Beat with bc==7 accepted: f[wp]<=1, wp toggles, bc<=0.
- in_sof on an accepted beat:
  - bc==0: normal frame start; no effect.
  - bc!=0: the partial frame is discarded, frame_err pulses for one cycle, and the beat is stored as beat 0 (bc<=1).
  - Buffer contents are not cleared on a discard, and wp does not change.
- in_sof=1 is not required for alignment. With in_sof held 0, frames are cut every 8 accepted beats.
- out_valid = f[rp]. out_re/out_im = buf[rp], driven from registers.
- Frame take (out_valid && out_ready): f[rp]<=0, rp toggles.
- Frame fill and frame take in the same cycle always target different buffers, so both take effect.
- Output frame contents stay stable while out_valid && !out_ready.
- Sample order is natural (index n = time order). Bit-reversal is the core's job.
- No arithmetic and no width change: samples pass through bit-exact.

## Timing
- Latency: if the 8th beat is accepted at edge N, out_valid=1 from edge N onward, with the full frame visible in the same cycle.
- Throughput: one beat per cycle sustained, provided the core takes each frame within 8 cycles of out_valid.
- Both buffers full: in_ready=0 until the cycle after a frame take. The take at edge M gives in_ready=1 after edge M.
- Reset asserted mid-frame: all state returns to reset values immediately. The partial frame and any pending full frames are lost. No frame_err is raised.
- frame_err is registered: it is high in the cycle after the offending beat edge.

## Structure
- Shared package fft16_pkg:
  - FFT_N=16, BEATS=8, BC_W=3, DW default.
  - Complex sample struct (re, im) used by both this block and the output serializer.
- One natural sub-module, fft16_frame_buf: a single 16-word buffer with a write port for 2 words per beat and a full parallel read port. It is instantiated twice.
- The control logic (wp/rp/f/bc/frame_err) lives in the top level.

## Test plan
- Reset: hold rst_n=0, release -> in_ready=1, out_valid=0, outputs 0, frame_err=0.
- Single frame: 8 beats with re=n, im=-n (n=0..15), out_ready=0 -> out_valid rises at the 8th beat edge, out_re word n = n, out_im word n = -n, and the frame holds stable.
- Backpressure: 3 frames back-to-back with out_ready=0 -> in_ready falls after the 16th beat. Assert out_ready for 1 cycle -> frame 0 taken, in_ready=1 next cycle, frame 1 is now presented.
- Streaming: out_ready=1 with continuous in_valid for 4 frames -> in_ready never drops, one out_valid&&out_ready per 8 cycles, data matches in order.
- Resync: in_sof=1 on beat 3 -> frame_err pulses once, the next 7 beats complete a frame whose sample 0/1 come from the sof beat.
- Reset mid-operation: assert rst_n=0 after 5 beats with one full frame pending -> out_valid=0, in_ready=1 immediately. A fresh 8-beat frame afterwards is delivered correctly.

Source files
------------

// File: rtl/fft16_pkg.sv
// rtl/fft16_pkg.sv - shared constants, sample type and helpers for the 16-point FFT datapath
package fft16_pkg;

  localparam int FFT_N      = 16;
  localparam int BEATS      = 8;
  localparam int BC_W       = 3;
  localparam int IDX_W      = 4;
  localparam int DW_DEFAULT = 16;

  typedef struct packed {
    logic [DW_DEFAULT-1:0] re;
    logic [DW_DEFAULT-1:0] im;
  } cplx_t;

  // Beat k carries natural-order samples 2k (even) and 2k+1 (odd).
  function automatic logic [IDX_W-1:0] word_idx(input logic [BC_W-1:0] beat, input logic odd);
    return {beat, odd};
  endfunction

endpackage

// File: rtl/fft16_frame_buf.sv
// rtl/fft16_frame_buf.sv - one 16-word complex frame buffer, 2-word write per beat, full parallel read
module fft16_frame_buf
  import fft16_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [BC_W-1:0]     beat,
  input  logic [DW-1:0]       w0_re,
  input  logic [DW-1:0]       w0_im,
  input  logic [DW-1:0]       w1_re,
  input  logic [DW-1:0]       w1_im,
  output logic [FFT_N*DW-1:0] rd_re,
  output logic [FFT_N*DW-1:0] rd_im
);

  logic [DW-1:0] re_q [FFT_N];
  logic [DW-1:0] im_q [FFT_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FFT_N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (we) begin
      re_q[word_idx(beat, 1'b0)] <= w0_re;
      im_q[word_idx(beat, 1'b0)] <= w0_im;
      re_q[word_idx(beat, 1'b1)] <= w1_re;
      im_q[word_idx(beat, 1'b1)] <= w1_im;
    end
  end

  for (genvar n = 0; n < FFT_N; n++) begin : g_rd
    assign rd_re[n*DW +: DW] = re_q[n];
    assign rd_im[n*DW +: DW] = im_q[n];
  end

endmodule

// File: rtl/fft16_ser2par.sv
// rtl/fft16_ser2par.sv - ping-pong serial-to-parallel frame assembler feeding the FFT core
module fft16_ser2par
  import fft16_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [DW-1:0]       in0_re,
  input  logic [DW-1:0]       in0_im,
  input  logic [DW-1:0]       in1_re,
  input  logic [DW-1:0]       in1_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FFT_N*DW-1:0] out_re,
  output logic [FFT_N*DW-1:0] out_im,
  output logic                frame_err
);

  logic [1:0]      full_q;
  logic            wp_q;
  logic            rp_q;
  logic [BC_W-1:0] bc_q;
  logic            frame_err_q;

  logic            accept;
  logic            take;
  logic            resync;
  logic            last_beat;
  logic [BC_W-1:0] wr_beat;
  logic [1:0]      set_mask;
  logic [1:0]      clr_mask;

  logic [FFT_N*DW-1:0] b0_re, b0_im, b1_re, b1_im;

  assign in_ready  = !full_q[wp_q];
  assign out_valid = full_q[rp_q];
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // A start marker mid-frame restarts the current buffer at beat 0; old words are simply overwritten.
  assign resync    = accept && in_sof && (bc_q != '0);
  assign wr_beat   = resync ? '0 : bc_q;
  assign last_beat = accept && (wr_beat == BC_W'(BEATS - 1));

  // Fill needs f[wp]=0 and take needs f[rp]=1, so the two masks never hit the same bit.
  assign set_mask = last_beat ? (wp_q ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = take      ? (rp_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= 2'b00;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      bc_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= resync;
      full_q      <= (full_q & ~clr_mask) | set_mask;
      if (accept)    bc_q <= wr_beat + BC_W'(1);
      if (last_beat) wp_q <= !wp_q;
      if (take)      rp_q <= !rp_q;
    end
  end

  assign frame_err = frame_err_q;

  fft16_frame_buf #(.DW(DW)) u_buf0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept && !wp_q),
    .beat  (wr_beat),
    .w0_re (in0_re),
    .w0_im (in0_im),
    .w1_re (in1_re),
    .w1_im (in1_im),
    .rd_re (b0_re),
    .rd_im (b0_im)
  );

  fft16_frame_buf #(.DW(DW)) u_buf1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept && wp_q),
    .beat  (wr_beat),
    .w0_re (in0_re),
    .w0_im (in0_im),
    .w1_re (in1_re),
    .w1_im (in1_im),
    .rd_re (b1_re),
    .rd_im (b1_im)
  );

  assign out_re = rp_q ? b1_re : b0_re;
  assign out_im = rp_q ? b1_im : b0_im;

endmodule

// File: tb/tb_fft16_ser2par.sv
// tb/tb_fft16_ser2par.sv - self-checking bench for fft16_ser2par with a frame scoreboard
module tb_fft16_ser2par;
  import fft16_pkg::*;

  localparam int DW = 16;
  localparam int FW = FFT_N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in0_re = '0, in0_im = '0, in1_re = '0, in1_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FW-1:0] out_re, out_im;
  logic          frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_take = 0;

  logic [FW-1:0] exp_re_q[$];
  logic [FW-1:0] exp_im_q[$];
  logic [FW-1:0] cur_re, cur_im;
  logic [FW-1:0] mon_re, mon_im;
  int            bc_m = 0;
  logic          last_acc;

  always #5 clk = ~clk;

  fft16_ser2par #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in0_re    (in0_re),
    .in0_im    (in0_im),
    .in1_re    (in1_re),
    .in1_im    (in1_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .frame_err (frame_err)
  );

  function automatic logic [DW-1:0] samp_re(input int fid, input int n);
    return DW'(fid * 256 + n);
  endfunction

  function automatic logic [DW-1:0] samp_im(input int fid, input int n);
    logic [DW-1:0] t;
    t = samp_re(fid, n);
    return -t;
  endfunction

  function automatic logic [FW-1:0] frame_re(input int fid);
    logic [FW-1:0] v;
    for (int n = 0; n < FFT_N; n++) v[n*DW +: DW] = samp_re(fid, n);
    return v;
  endfunction

  function automatic logic [FW-1:0] frame_im(input int fid);
    logic [FW-1:0] v;
    for (int n = 0; n < FFT_N; n++) v[n*DW +: DW] = samp_im(fid, n);
    return v;
  endfunction

  // Scoreboard: every frame take is compared against the oldest completed frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_take++;
      n_chk++;
      if (exp_re_q.size() == 0) begin
        $display("FAIL take_unexpected: got frame re=%h, required no frame", out_re);
      end else begin
        mon_re = exp_re_q.pop_front();
        mon_im = exp_im_q.pop_front();
        if (out_re !== mon_re || out_im !== mon_im)
          $display("FAIL take_data: got re=%h im=%h, required re=%h im=%h", out_re, out_im, mon_re, mon_im);
        else
          n_pass++;
      end
    end
  end

  // Drives one beat for one cycle; updates the reference frame if it was accepted.
  task automatic beat(input int fid, input int k, input logic sof);
    logic acc;
    in_valid = 1'b1;
    in_sof   = sof;
    in0_re   = samp_re(fid, 2*k);
    in0_im   = samp_im(fid, 2*k);
    in1_re   = samp_re(fid, 2*k + 1);
    in1_im   = samp_im(fid, 2*k + 1);
    acc      = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (acc) begin
      if (sof) bc_m = 0;
      cur_re[(2*bc_m)*DW +: DW]   = samp_re(fid, 2*k);
      cur_im[(2*bc_m)*DW +: DW]   = samp_im(fid, 2*k);
      cur_re[(2*bc_m+1)*DW +: DW] = samp_re(fid, 2*k + 1);
      cur_im[(2*bc_m+1)*DW +: DW] = samp_im(fid, 2*k + 1);
      bc_m++;
      if (bc_m == BEATS) begin
        exp_re_q.push_back(cur_re);
        exp_im_q.push_back(cur_im);
        bc_m = 0;
      end
    end
    last_acc = acc;
  endtask

  task automatic take_one();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else n_pass++;
    n_chk++; if (out_re !== '0 || out_im !== '0) $display("FAIL reset_out_data: got re=%h im=%h, required 0", out_re, out_im); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, required 0", frame_err); else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [FW-1:0] er, ei;
    logic [DW-1:0] nv;
    for (int n = 0; n < FFT_N; n++) begin
      nv = DW'(n);
      er[n*DW +: DW] = nv;
      ei[n*DW +: DW] = -nv;
    end
    out_ready = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      beat(0, k, k == 0);
      if (k == BEATS - 2) begin
        n_chk++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b, required 0", out_valid); else n_pass++;
      end
    end
    n_chk++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b, required 1", out_valid); else n_pass++;
    n_chk++; if (out_re !== er || out_im !== ei) $display("FAIL single_data: got re=%h im=%h, required re=%h im=%h", out_re, out_im, er, ei); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b1 || out_re !== er || out_im !== ei) $display("FAIL single_hold: got valid=%b re=%h, required valid=1 re=%h", out_valid, out_re, er); else n_pass++;
    take_one();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL single_after_take: got %b, required 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int f = 1; f <= 2; f++)
      for (int k = 0; k < BEATS; k++) beat(f, k, k == 0);
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b, required 0", in_ready); else n_pass++;
    beat(3, 0, 1'b1);
    beat(3, 0, 1'b1);
    n_chk++; if (last_acc !== 1'b0 || in_ready !== 1'b0) $display("FAIL bp_blocked: got acc=%b ready=%b, required 0 0", last_acc, in_ready); else n_pass++;
    take_one();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_take: got %b, required 1", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b1 || out_re !== frame_re(2) || out_im !== frame_im(2))
      $display("FAIL bp_next_frame: got valid=%b re=%h, required valid=1 re=%h", out_valid, out_re, frame_re(2)); else n_pass++;
    take_one();
  endtask

  task automatic test_streaming();
    int take0;
    int drops;
    take0 = n_take;
    drops = 0;
    out_ready = 1'b1;
    for (int f = 10; f < 14; f++)
      for (int k = 0; k < BEATS; k++) begin
        beat(f, k, k == 0);
        if (!last_acc) drops++;
      end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_chk++; if (drops !== 0) $display("FAIL stream_ready_drops: got %0d, required 0", drops); else n_pass++;
    n_chk++; if (n_take - take0 !== 4) $display("FAIL stream_takes: got %0d, required 4", n_take - take0); else n_pass++;
    n_chk++; if (exp_re_q.size() !== 0) $display("FAIL stream_pending: got %0d frames, required 0", exp_re_q.size()); else n_pass++;
  endtask

  task automatic test_resync();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) beat(20, k, k == 0);
    beat(21, 0, 1'b1);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL resync_err_pulse: got %b, required 1", frame_err); else n_pass++;
    beat(21, 1, 1'b0);
    n_chk++; if (frame_err !== 1'b0) $display("FAIL resync_err_clear: got %b, required 0", frame_err); else n_pass++;
    for (int k = 2; k < BEATS; k++) beat(21, k, 1'b0);
    n_chk++; if (out_valid !== 1'b1 || out_re !== frame_re(21) || out_im !== frame_im(21))
      $display("FAIL resync_frame: got valid=%b re=%h, required valid=1 re=%h", out_valid, out_re, frame_re(21)); else n_pass++;
    take_one();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < BEATS; k++) beat(30, k, k == 0);
    for (int k = 0; k < 5; k++) beat(31, k, k == 0);
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_flags: got valid=%b ready=%b, required 0 1", out_valid, in_ready); else n_pass++;
    n_chk++; if (out_re !== '0 || frame_err !== 1'b0) $display("FAIL rstmid_clear: got re=%h err=%b, required 0 0", out_re, frame_err); else n_pass++;
    exp_re_q.delete();
    exp_im_q.delete();
    bc_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < BEATS; k++) beat(32, k, k == 0);
    n_chk++; if (frame_err !== 1'b0) $display("FAIL rstmid_err: got %b, required 0", frame_err); else n_pass++;
    n_chk++; if (out_valid !== 1'b1 || out_re !== frame_re(32) || out_im !== frame_im(32))
      $display("FAIL rstmid_frame: got valid=%b re=%h, required valid=1 re=%h", out_valid, out_re, frame_re(32)); else n_pass++;
    take_one();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_streaming();
    test_resync();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
